// File: rtl/rgf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rgf_wb_arbiter
//   Shares the register file's single write port between the main pipeline
//   WB stage (source A, normally favoured) and the multi-cycle unit
//   (source B, late results). B is promoted over A after STARVE_LIMIT
//   consecutive refusals. A busy-bit scoreboard tracks destinations with a
//   B result still outstanding and drives the decode RAW stall.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   hold                   global pipeline hold, blocks all acceptance
//   a_valid/a_addr/a_data  A write request, a_ready = accepted this cycle
//   b_valid/b_addr/b_data  B write request, b_ready = accepted this cycle
//   issue_valid/issue_addr decode issuing a B-unit op, issue_ready = allowed
//   query_addr_1/_2        decode source registers, stall = one is busy
//   rf_write*              registered write port to mod_register_file
// ---------------------------------------------------------------------------
module rgf_wb_arbiter #(
   parameter int DATA_W          = 32,
   parameter int ADDR_W          = 5,
   parameter int STARVE_LIMIT    = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              issue_ready,
   input  logic [ADDR_W-1:0] query_addr_1,
   input  logic [ADDR_W-1:0] query_addr_2,
   output logic              stall,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_write_address,
   output logic [DATA_W-1:0] rf_write_data
);

   localparam int NREG = 1 << ADDR_W;
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   localparam int OC_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
   localparam logic [OC_W-1:0] OUT_MAX    = OC_W'(MAX_OUTSTANDING);

   logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
   logic [OC_W-1:0]   outstanding_q, outstanding_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic              rf_write_q, rf_write_d;
   logic              wr_from_b_q, wr_from_b_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0] rf_data_q, rf_data_d;

   logic b_pri, a_acc, b_acc, issue_acc, sb_set, sb_clr;

   // Arbitration: the readies are mutually exclusive whenever both sources
   // are valid, so at most one acceptance happens per cycle.
   assign b_pri       = (starve_cnt_q >= STARVE_MAX);
   assign a_ready     = !hold && !(b_valid && b_pri);
   assign b_ready     = !hold && (!a_valid || b_pri);
   assign a_acc       = a_valid && a_ready;
   assign b_acc       = b_valid && b_ready;

   // Issue is judged on the current busy bits only; a clear landing this
   // same cycle does not make the register issuable until the next one.
   assign issue_ready = !hold && !busy_q[issue_addr] && (outstanding_q < OUT_MAX);
   assign issue_acc   = issue_valid && issue_ready;
   assign sb_set      = issue_acc && (issue_addr != '0);
   // A B write to a register that is not busy leaves the count alone, so
   // the outstanding counter can never underflow.
   assign sb_clr      = rf_write_q && wr_from_b_q && busy_q[rf_addr_q];

   assign stall            = busy_q[query_addr_1] || busy_q[query_addr_2];
   assign rf_write         = rf_write_q;
   assign rf_write_address = rf_addr_q;
   assign rf_write_data    = rf_data_q;

   always_comb begin
      rf_write_d  = 1'b0;
      wr_from_b_d = 1'b0;
      rf_addr_d   = rf_addr_q;
      rf_data_d   = rf_data_q;
      // Writes to register 0 complete the handshake but never assert the
      // write strobe, so they can neither commit nor clear a busy bit.
      if (a_acc) begin
         rf_write_d = (a_addr != '0);
         rf_addr_d  = a_addr;
         rf_data_d  = a_data;
      end else if (b_acc) begin
         rf_write_d  = (b_addr != '0);
         wr_from_b_d = 1'b1;
         rf_addr_d   = b_addr;
         rf_data_d   = b_data;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!hold) begin
         if (b_valid && !b_ready) begin
            if (starve_cnt_q < STARVE_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
         end else begin
            starve_cnt_d = '0;
         end
      end
   end

   always_comb begin
      busy_d        = busy_q;
      outstanding_d = outstanding_q;
      // Clear first so that a set on the same register wins.
      if (sb_clr) busy_d[rf_addr_q] = 1'b0;
      if (sb_set) busy_d[issue_addr] = 1'b1;
      busy_d[0] = 1'b0;
      case ({sb_set, sb_clr})
         2'b10:   outstanding_d = outstanding_q + 1'b1;
         2'b01:   outstanding_d = outstanding_q - 1'b1;
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_q  <= '0;
         outstanding_q <= '0;
         busy_q        <= '0;
         rf_write_q    <= 1'b0;
         wr_from_b_q   <= 1'b0;
         rf_addr_q     <= '0;
         rf_data_q     <= '0;
      end else begin
         starve_cnt_q  <= starve_cnt_d;
         outstanding_q <= outstanding_d;
         busy_q        <= busy_d;
         rf_write_q    <= rf_write_d;
         wr_from_b_q   <= wr_from_b_d;
         rf_addr_q     <= rf_addr_d;
         rf_data_q     <= rf_data_d;
      end
   end

endmodule

// File: doc/rgf_wb_arbiter.md
Name: rgf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources:
  - A: the main pipeline's WB stage, normally the priority source.
  - B: the multi-cycle unit (mul/div, long loads), which returns results late.
- Keeps a scoreboard of destination registers that have a pending B result, and drives the decode-stage stall on RAW hazards against them.
- Sits between the WB sources and mod_register_file; drives its write, write_address and write_data inputs.

Parameters:
- DATA_W, 32, data width of the register file write port.
- ADDR_W, 5, register address width.
- STARVE_LIMIT, 4, consecutive cycles B may be refused before it takes priority over A.
- MAX_OUTSTANDING, 4, maximum issued-but-unwritten B operations.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- hold  in  1  global pipeline hold; no acceptance while high
- a_valid  in  1  A has a write pending
- a_addr  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write data
- a_ready  out  1  A accepted this cycle when a_valid && a_ready
- b_valid  in  1  B has a result pending
- b_addr  in  ADDR_W  B destination register
- b_data  in  DATA_W  B result data
- b_ready  out  1  B accepted this cycle when b_valid && b_ready
- issue_valid  in  1  decode issues a B-unit operation
- issue_addr  in  ADDR_W  destination register of the issued operation
- issue_ready  out  1  issue permitted
- query_addr_1  in  ADDR_W  decode source register 1
- query_addr_2  in  ADDR_W  decode source register 2
- stall  out  1  a queried source register is busy
- rf_write  out  1  write enable to the register file
- rf_write_address  out  ADDR_W  write address
- rf_write_data  out  DATA_W  write data

Behaviour:
Reset (synchronous, takes effect at the clock edge):
- rf_write=0, rf_write_address=0, rf_write_data=0.
- Scoreboard cleared, starve_cnt=0, outstanding=0.
- Reset mid-operation drops any in-flight write and all pending bits.

Arbitration (combinational ready signals):
- b_pri = (starve_cnt >= STARVE_LIMIT).
- a_ready = !hold && !(b_valid && b_pri).
- b_ready = !hold && (!a_valid || b_pri).
- At most one source is accepted per cycle.
- While hold=1 both readies are 0 and starve_cnt does not change.

Starvation counter:
- starve_cnt increments, saturating at STARVE_LIMIT, when b_valid && !b_ready && !hold.
- Clears to 0 when B is accepted or b_valid=0.

Write port (registered, 1-cycle latency):
- Acceptance in cycle N gives rf_write=1 in cycle N+1, with the winner's address and data.
- With no acceptance, rf_write=0 and address/data hold their previous values.
- An accepted write to address 0 gives rf_write=0; the handshake still completes.

Scoreboard (busy[1..31]; busy[0] is hardwired 0):
- Set: on issue_valid && issue_ready, set busy[issue_addr] and increment outstanding.
- Clear: at the edge ending a cycle in which rf_write=1 from a B acceptance, clear busy[rf_write_address] and decrement outstanding. The register file commits at that same edge.
- Set and clear on the same register in the same cycle: set wins; outstanding stays unchanged (net).
- Issue to address 0: accepted, no bit is set, outstanding is unchanged.
- B write to a register that is not busy: written; the scoreboard is unchanged and outstanding does not underflow.
- issue_ready = !hold && !busy[issue_addr] && (outstanding < MAX_OUTSTANDING).
  - A simultaneous clear in the same cycle does not raise issue_ready.
- stall = busy[query_addr_1] || busy[query_addr_2] (combinational).
- A must never target a busy register; decode guarantees this. The arbiter does not check it.

Test Plan:
- Reset sanity: assert reset for 2 cycles mid-traffic -> rf_write=0, stall=0, issue_ready=1, outstanding=0 on release.
- A-only: a_valid with addr 5 and data 0x1234 held 3 cycles, B idle -> a_ready=1 each cycle; rf_write=1 one cycle later with addr 5 and data 0x1234; no bubbles.
- Starvation: a_valid continuous, b_valid with addr 7 from cycle 0 -> b_ready=0 for cycles 0-3, b_ready=1 and a_ready=0 in cycle 4; rf_write addr 7 in cycle 5; A resumes in cycle 5.
- Scoreboard: issue addr 9, query_addr_1=9 -> stall=1 from the next cycle; B writes 9 -> stall drops two cycles after B acceptance; re-issue to 9 refused while busy.
- Limits: issue 4 distinct registers -> issue_ready=0 on a 5th, new register; one B writeback restores issue_ready the cycle after the clear.
- Hold and zero register: hold=1 with both valid -> no readies, starve_cnt frozen; B accepted with addr 0 -> rf_write stays 0 and the handshake completes.
